player_hand: RTL
================

# player_hand

Per-player card store: the requesting side of the deck draw handshake. On a draw-1/2/4 command from the game controller it holds a draw request to the deck and captures each card strobed back. It keeps the cards in a compacted array, removes a card when it is played, and gives the display/rule logic random read access plus count, UNO and full flags. One instance sits between the deck and the game controller per player.

## Interface
- MAX_CARDS, 32, hand capacity. Power of two, 8..64. IW = $clog2(MAX_CARDS); count width CW = IW+1.
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_draw  in  3  one-hot command: 001 draw one, 010 draw two, 100 draw four, 000 none.
- i_play  in  1  single-cycle strobe: remove the card at i_play_idx.
- i_play_idx  in  IW  slot to remove.
- i_rd_idx  in  IW  combinational read address.
- i_deck_done  in  1  deck idle/ready (deck's done output).
- i_drawn  in  1  deck card-valid strobe; one pulse per card.
- i_card  in  6  card code {color[5:4], value[3:0]}; valid when i_drawn=1.
- o_draw  out  3  one-hot draw request to the deck; held for the whole transfer.
- o_busy  out  1  draw transfer in progress.
- o_play_valid  out  1  one-cycle pulse: o_play_card is valid.
- o_play_card  out  6  card removed by the last accepted play.
- o_rd_card  out  6  card at i_rd_idx. Reads 0 when i_rd_idx >= o_count.
- o_count  out  CW  cards held.
- o_empty / o_full / o_uno  out  1 each  count==0 / count==MAX_CARDS / count==1.
- o_err  out  1  one-cycle pulse: command rejected.

## Operation
- State machine with three states: IDLE, WAIT_DECK, DRAW.
  - o_busy = (state != IDLE).
  - o_draw is nonzero only in DRAW.
- IDLE:
  - Valid one-hot i_req_draw with o_count + N <= MAX_CARDS (N = 1, 2 or 4): latch the one-hot as req_r, load need_r = N, go to WAIT_DECK.
  - i_req_draw with more than one bit set, or capacity would be exceeded: o_err pulse, stay in IDLE, no state change.
- WAIT_DECK:
  - Stay while i_deck_done=0.
  - When i_deck_done=1, go to DRAW.
- DRAW:
  - o_draw = req_r.
  - Each cycle with i_drawn=1: write i_card to slot o_count, increment count, decrement need_r.
  - If the decrement takes need_r to 0, go to IDLE.
  - i_drawn in IDLE or WAIT_DECK is ignored; no capture, no error.
- Play:
  - Accepted only in IDLE with i_play_idx < o_count.
  - Slots idx+1..count-1 shift down by one in the same edge. The vacated top slot is cleared to 0. Count decrements.
  - o_play_card = old slot[idx] and o_play_valid=1 in the following cycle.
  - A play in a busy state, or with i_play_idx >= o_count: o_err pulse, hand unchanged.
- Simultaneous i_play and a valid i_req_draw in IDLE:
  - The play executes if it is legal.
  - The draw is dropped with an o_err pulse. If the play is also illegal, there is still a single o_err pulse.
- Card order is arrival order. Compaction preserves the relative order of the remaining cards.
- o_uno, o_empty and o_full are derived combinationally from the count register.

## Timing
- Reset values:
  - state IDLE, count 0, need_r 0, req_r 000, all slots 0.
  - o_draw 000, o_busy 0, o_play_valid 0, o_play_card 0, o_err 0.
  - o_empty 1, o_full 0, o_uno 0, o_rd_card 0.
- Asserting reset mid-transfer aborts the transfer immediately: o_draw drops asynchronously and the hand is cleared.
- Draw request latency: i_req_draw sampled at edge t → o_busy=1 in cycle t+1. If i_deck_done=1 in cycle t+1 → o_draw asserted in cycle t+2.
- Card capture: i_drawn sampled at edge t → o_count and the slot are updated in cycle t+1.
- Final card at edge t → state IDLE and o_draw=000 in cycle t+1. A new command is accepted in cycle t+1.
- Back-to-back i_drawn pulses on consecutive cycles are all captured.
- Play: i_play sampled at edge t → count, slots, o_play_card and o_play_valid update in cycle t+1. o_play_valid clears at t+2.
- o_err is a registered single-cycle pulse, asserted the cycle after the offending input.
- o_rd_card is a pure combinational mux with zero latency.
- Count never wraps: the draw capacity check and the play index check make overflow and underflow unreachable.

## Test plan
- Reset, then i_req_draw=100 with i_deck_done=1 and four i_drawn pulses with cards 0x01, 0x12, 0x2C, 0x3E → o_draw=100 until the cycle after the 4th pulse; o_count=4; slots 0..3 read 0x01, 0x12, 0x2C, 0x3E.
- Play idx 1 from that hand → o_play_card=0x12 with a one-cycle o_play_valid; o_count=3; slots read 0x01, 0x2C, 0x3E; slot 3 reads 0.
- Hand with 30 of 32 cards, i_req_draw=100 → o_err pulse, o_busy stays 0, count 30. i_req_draw=010 then two cards → count 32, o_full=1.
- i_req_draw=011, then a play with idx=o_count, then a play during DRAW → one o_err pulse for each; hand unchanged.
- i_req_draw=001 with i_deck_done=0 for 5 cycles → o_draw stays 000 until i_deck_done rises. Assert i_rst while in DRAW → every output returns to its reset value.
- Hand of 2 cards, play idx 0 → o_uno=1. Play idx 0 again → o_empty=1, o_uno=0.

Source files
------------

// File: rtl/player_hand.sv
// rtl/player_hand.sv - per-player card store: draws cards from the deck, keeps them compacted, removes played cards
module player_hand #(
    parameter int MAX_CARDS = 32,
    localparam int IW = $clog2(MAX_CARDS),
    localparam int CW = IW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [2:0]    i_req_draw,
    input  logic          i_play,
    input  logic [IW-1:0] i_play_idx,
    input  logic [IW-1:0] i_rd_idx,
    input  logic          i_deck_done,
    input  logic          i_drawn,
    input  logic [5:0]    i_card,
    output logic [2:0]    o_draw,
    output logic          o_busy,
    output logic          o_play_valid,
    output logic [5:0]    o_play_card,
    output logic [5:0]    o_rd_card,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_uno,
    output logic          o_err
);

    typedef enum logic [1:0] {IDLE, WAIT_DECK, DRAW} state_t;

    localparam logic [CW:0] MAX_W = (CW+1)'(MAX_CARDS);

    state_t        state;
    logic [5:0]    slots [MAX_CARDS];
    logic [2:0]    req_r;
    logic [2:0]    need_r;
    logic [CW-1:0] count;

    logic req_onehot;
    logic room_ok;
    logic req_ok;
    logic idx_ok;

    // A one-hot request encodes its own card count (001=1, 010=2, 100=4).
    assign req_onehot = (i_req_draw == 3'b001) || (i_req_draw == 3'b010) || (i_req_draw == 3'b100);
    assign room_ok    = ({1'b0, count} + {{(CW-2){1'b0}}, i_req_draw}) <= MAX_W;
    assign req_ok     = req_onehot && room_ok;
    assign idx_ok     = {1'b0, i_play_idx} < count;

    assign o_busy    = (state != IDLE);
    assign o_count   = count;
    assign o_empty   = (count == '0);
    assign o_full    = (count == MAX_W[CW-1:0]);
    assign o_uno     = (count == CW'(1));
    assign o_rd_card = ({1'b0, i_rd_idx} < count) ? slots[i_rd_idx] : 6'h00;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            req_r        <= 3'b000;
            need_r       <= 3'b000;
            count        <= '0;
            o_draw       <= 3'b000;
            o_play_valid <= 1'b0;
            o_play_card  <= 6'h00;
            o_err        <= 1'b0;
            for (int i = 0; i < MAX_CARDS; i++) begin
                slots[i] <= 6'h00;
            end
        end else begin
            o_play_valid <= 1'b0;
            o_err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_play) begin
                        // Play wins over a simultaneous draw; the draw is always dropped.
                        if (idx_ok) begin
                            for (int i = 0; i < MAX_CARDS - 1; i++) begin
                                if (IW'(i) >= i_play_idx) begin
                                    slots[i] <= slots[i+1];
                                end
                            end
                            slots[MAX_CARDS-1] <= 6'h00;
                            count              <= count - CW'(1);
                            o_play_card        <= slots[i_play_idx];
                            o_play_valid       <= 1'b1;
                        end
                        if (!idx_ok || (i_req_draw != 3'b000)) begin
                            o_err <= 1'b1;
                        end
                    end else if (i_req_draw != 3'b000) begin
                        if (req_ok) begin
                            req_r  <= i_req_draw;
                            need_r <= i_req_draw;
                            state  <= WAIT_DECK;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                WAIT_DECK: begin
                    if (i_play) begin
                        o_err <= 1'b1;
                    end
                    if (i_deck_done) begin
                        state  <= DRAW;
                        o_draw <= req_r;
                    end
                end
                DRAW: begin
                    if (i_play) begin
                        o_err <= 1'b1;
                    end
                    if (i_drawn) begin
                        slots[count[IW-1:0]] <= i_card;
                        count                <= count + CW'(1);
                        need_r               <= need_r - 3'd1;
                        if (need_r == 3'd1) begin
                            state  <= IDLE;
                            o_draw <= 3'b000;
                            req_r  <= 3'b000;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_draw <= 3'b000;
                end
            endcase
        end
    end

endmodule
